// File: rtl/decrypt_depad_ctrl.sv
// Decrypt/depad sequencer: captures the LFSR preamble, identifies the tap pattern,
// decrypts and parity-checks 64 ciphertext bytes, strips leading spaces and pads with zeros.
module decrypt_depad_ctrl #(
  parameter int unsigned IN_BASE   = 64,
  parameter int unsigned NUM_BYTES = 64,
  parameter int unsigned SEED_LEN  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  output logic       MemWrEn,
  output logic [7:0] MemWrData,
  input  logic [7:0] MemRdData,
  output logic [3:0] PtrnIdx,
  output logic       PtrnFound,
  output logic [6:0] ErrCount
);

  localparam int unsigned NumPtrn = 9;
  localparam int unsigned CntW    = $clog2(NUM_BYTES + 1);
  localparam int unsigned SeqW    = ($clog2(SEED_LEN) > 4) ? $clog2(SEED_LEN) : 4;

  typedef enum logic [2:0] {
    StIdle, StCapture, StMatch, StRd, StWr, StPad, StDone
  } state_e;

  function automatic logic [6:0] tap(input logic [3:0] idx);
    logic [6:0] t;
    case (idx)
      4'd0:    t = 7'h60;
      4'd1:    t = 7'h48;
      4'd2:    t = 7'h78;
      4'd3:    t = 7'h72;
      4'd4:    t = 7'h6A;
      4'd5:    t = 7'h69;
      4'd6:    t = 7'h5C;
      4'd7:    t = 7'h7E;
      4'd8:    t = 7'h7B;
      default: t = 7'h60;
    endcase
    return t;
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] p);
    return {s[5:0], ^(s & p)};
  endfunction

  state_e            state_q, state_d;
  logic              start_q;
  logic [SeqW-1:0]   seq_q, seq_d;
  logic [6:0]        seed_q [SEED_LEN];
  logic [6:0]        seed_d [SEED_LEN];
  logic [6:0]        lfsr_q, lfsr_d;
  logic [3:0]        ptrn_idx_q, ptrn_idx_d;
  logic              found_q, found_d;
  logic [6:0]        err_q, err_d;
  logic              skip_q, skip_d;
  logic [CntW-1:0]   in_cnt_q, in_cnt_d;
  logic [CntW-1:0]   out_cnt_q, out_cnt_d;
  logic              perr_q, perr_d;
  logic [6:0]        plain_q, plain_d;

  logic              launch;
  logic              ptrn_match;
  logic              rd_perr;
  logic [6:0]        rd_plain;

  assign launch    = start_q & ~Start;
  assign rd_perr   = ^MemRdData;
  assign rd_plain  = MemRdData[6:0] ^ lfsr_q;
  assign PtrnIdx   = ptrn_idx_q;
  assign PtrnFound = found_q;
  assign ErrCount  = err_q;

  // Pattern under test (seq_q) must reproduce every captured state transition.
  always_comb begin
    ptrn_match = 1'b1;
    for (int k = 0; k < int'(SEED_LEN) - 1; k++) begin
      if (lfsr_step(seed_q[k], tap(seq_q[3:0])) != seed_q[k+1]) ptrn_match = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    seed_d     = seed_q;
    lfsr_d     = lfsr_q;
    ptrn_idx_d = ptrn_idx_q;
    found_d    = found_q;
    err_d      = err_q;
    skip_d     = skip_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    perr_d     = perr_q;
    plain_d    = plain_q;
    Ack        = 1'b0;
    MemAddr    = 8'h00;
    MemWrEn    = 1'b0;
    MemWrData  = 8'h00;

    unique case (state_q)
      StIdle, StDone: begin
        Ack = (state_q == StDone);
        if (launch) begin
          state_d    = StCapture;
          seq_d      = '0;
          ptrn_idx_d = 4'd0;
          found_d    = 1'b0;
          err_d      = 7'd0;
          skip_d     = 1'b1;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
        end
      end
      StCapture: begin
        MemAddr = 8'(IN_BASE) + 8'(seq_q);
        for (int k = 0; k < int'(SEED_LEN); k++) begin
          if (seq_q == SeqW'(k)) seed_d[k] = MemRdData[6:0];
        end
        if (seq_q == SeqW'(SEED_LEN - 1)) begin
          seq_d   = '0;
          state_d = StMatch;
        end else begin
          seq_d = seq_q + 1'b1;
        end
      end
      StMatch: begin
        if (ptrn_match && !found_q) begin
          found_d    = 1'b1;
          ptrn_idx_d = seq_q[3:0];
        end
        if (seq_q == SeqW'(NumPtrn - 1)) begin
          seq_d   = '0;
          lfsr_d  = seed_q[0];
          state_d = StRd;
        end else begin
          seq_d = seq_q + 1'b1;
        end
      end
      StRd: begin
        MemAddr  = 8'(IN_BASE) + 8'(in_cnt_q);
        lfsr_d   = lfsr_step(lfsr_q, tap(ptrn_idx_q));
        in_cnt_d = in_cnt_q + 1'b1;
        if (skip_q && (rd_plain == 7'd0) && !rd_perr) begin
          state_d = (in_cnt_q == CntW'(NUM_BYTES - 1)) ? StPad : StRd;
        end else begin
          perr_d  = rd_perr;
          plain_d = rd_plain;
          skip_d  = 1'b0;
          if (rd_perr && (err_q != 7'h7F)) err_d = err_q + 7'd1;
          state_d = StWr;
        end
      end
      StWr: begin
        MemAddr   = 8'(out_cnt_q);
        MemWrEn   = 1'b1;
        MemWrData = perr_q ? 8'h80 : {1'b0, plain_q};
        out_cnt_d = out_cnt_q + 1'b1;
        state_d   = (in_cnt_q == CntW'(NUM_BYTES)) ? StPad : StRd;
      end
      StPad: begin
        // One extra non-writing cycle once the output block is full.
        if (out_cnt_q < CntW'(NUM_BYTES)) begin
          MemAddr   = 8'(out_cnt_q);
          MemWrEn   = 1'b1;
          out_cnt_d = out_cnt_q + 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      seq_q      <= '0;
      for (int k = 0; k < int'(SEED_LEN); k++) seed_q[k] <= 7'd0;
      lfsr_q     <= 7'd0;
      ptrn_idx_q <= 4'd0;
      found_q    <= 1'b0;
      err_q      <= 7'd0;
      skip_q     <= 1'b0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      perr_q     <= 1'b0;
      plain_q    <= 7'd0;
    end else begin
      state_q    <= state_d;
      start_q    <= Start;
      seq_q      <= seq_d;
      seed_q     <= seed_d;
      lfsr_q     <= lfsr_d;
      ptrn_idx_q <= ptrn_idx_d;
      found_q    <= found_d;
      err_q      <= err_d;
      skip_q     <= skip_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      perr_q     <= perr_d;
      plain_q    <= plain_d;
    end
  end

endmodule

// File: tb/tb_decrypt_depad_ctrl.sv
// Randomized self-checking bench for decrypt_depad_ctrl: a behavioural memory plus a
// queue-level reference model of the decrypt/depad task.
module tb_decrypt_depad_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Ack;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;
  logic [3:0] PtrnIdx;
  logic       PtrnFound;
  logic [6:0] ErrCount;

  always #5 Clk = ~Clk;

  decrypt_depad_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .MemAddr   (MemAddr),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData),
    .MemRdData (MemRdData),
    .PtrnIdx   (PtrnIdx),
    .PtrnFound (PtrnFound),
    .ErrCount  (ErrCount)
  );

  logic [6:0] taps [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  logic [7:0] cin     [64];
  logic [7:0] out_mem [64];
  logic [6:0] plain   [64];

  assign MemRdData = (MemAddr >= 8'd64 && MemAddr < 8'd128) ? cin[MemAddr[5:0]] : 8'h00;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] p);
    return {s[5:0], ^(s & p)};
  endfunction

  // Reference expectations
  logic [7:0] exp_data [64];
  int         exp_idx, exp_found, exp_err, exp_lat;

  task automatic set_msg(input int pre, input string m);
    for (int i = 0; i < 64; i++) plain[i] = 7'h00;
    for (int i = 0; i < m.len() && pre + i < 64; i++) plain[pre+i] = 7'(m[i] - 8'h20);
  endtask

  task automatic encode(input logic [6:0] seed, input int pidx);
    logic [6:0] s, c7;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      c7     = plain[i] ^ s;
      cin[i] = {^c7, c7};
      s      = step(s, taps[pidx]);
    end
  endtask

  task automatic build_model();
    logic [6:0] s, pl;
    logic       pe, skipping, ok;
    int         n, skips;
    exp_found = 0;
    exp_idx   = 0;
    for (int p = 0; p < 9; p++) begin
      ok = 1'b1;
      for (int k = 0; k < 9; k++)
        if (step(cin[k][6:0], taps[p]) != cin[k+1][6:0]) ok = 1'b0;
      if (ok && exp_found == 0) begin
        exp_found = 1;
        exp_idx   = p;
      end
    end
    s = cin[0][6:0];
    n = 0; skips = 0; exp_err = 0; skipping = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pe = ^cin[i];
      pl = cin[i][6:0] ^ s;
      s  = step(s, taps[exp_idx]);
      if (skipping && pl == 7'd0 && !pe) begin
        skips++;
      end else begin
        skipping    = 1'b0;
        exp_data[n] = pe ? 8'h80 : {1'b0, pl};
        n++;
        if (pe) exp_err++;
      end
    end
    for (int i = n; i < 64; i++) exp_data[i] = 8'h00;
    exp_lat = 10 + 9 + skips + 2 * n + (64 - n) + 1;
  endtask

  // Compare process: every cycle of a monitored run
  int run_id = 0, seen_id = 0, wr_cnt = 0, cyc = 0;
  bit mon_en = 1'b0;

  always @(negedge Clk) begin
    if (mon_en) begin
      if (seen_id != run_id) begin
        seen_id = run_id;
        wr_cnt  = 0;
        cyc     = 0;
      end else begin
        cyc++;
        check("ack_timing", Ack, (cyc > exp_lat));
        if (MemWrEn) begin
          if (wr_cnt < 64) begin
            check("wr_addr", MemAddr, wr_cnt);
            check("wr_data", MemWrData, exp_data[wr_cnt]);
          end else begin
            check("wr_overflow", wr_cnt, 63);
          end
          if (MemAddr < 8'd64) out_mem[MemAddr[5:0]] = MemWrData;
          wr_cnt++;
        end
      end
    end
  end

  task automatic launch(input bit monitor);
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    if (monitor) begin
      mon_en = 1'b1;
      run_id++;
    end
  endtask

  task automatic run_and_check(input bit toggle);
    int bad;
    bit got;
    build_model();
    for (int i = 0; i < 64; i++) out_mem[i] = 8'hEE;
    launch(1'b1);
    @(posedge Clk);
    got = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge Clk);
      if (toggle && t == 60) Start = 1'b1;
      if (toggle && t == 62) Start = 1'b0;
      if (Ack) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_rise", got, 1'b1);
    repeat (3) @(negedge Clk);
    mon_en = 1'b0;
    check("ack_hold", Ack, 1'b1);
    check("write_count", wr_cnt, 64);
    check("ptrn_idx", PtrnIdx, exp_idx);
    check("ptrn_found", PtrnFound, exp_found);
    check("err_count", ErrCount, exp_err);
    bad = 0;
    for (int i = 0; i < 64; i++) if (out_mem[i] !== exp_data[i]) bad++;
    check("mem_image", bad, 0);
  endtask

  string      msg = "Mr. Watson, come here. I want to see you.";
  logic [7:0] pre_lit [10] = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'h41, 8'h03,
                               8'h06, 8'h0C};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] seed;
    int         pidx, pre;

    for (int i = 0; i < 64; i++) cin[i] = 8'h00;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_ack", Ack, 1'b0);
    check("rst_wren", MemWrEn, 1'b0);
    check("rst_addr", MemAddr, 8'h00);
    check("rst_idx", PtrnIdx, 4'd0);
    check("rst_found", PtrnFound, 1'b0);
    check("rst_err", ErrCount, 7'd0);
    @(posedge Clk); #1 Reset = 1'b1;

    // 1: seed 0x01, pattern 0x60
    set_msg(10, msg);
    encode(7'h01, 0);
    for (int i = 0; i < 10; i++) check("t1_preamble", cin[i], pre_lit[i]);
    run_and_check(1'b0);
    check("t1_mem0", out_mem[0], 8'h2D);
    check("t1_mem1", out_mem[1], 8'h52);
    check("t1_idx", PtrnIdx, 4'd0);
    check("t1_found", PtrnFound, 1'b1);
    check("t1_err", ErrCount, 7'd0);
    check("t1_mem63", out_mem[63], 8'h00);

    // 2: pattern 0x7B, random seed, Start toggled mid-run
    seed = 7'($urandom_range(1, 127));
    encode(seed, 8);
    run_and_check(1'b1);
    check("t2_idx", PtrnIdx, 4'd8);
    check("t2_found", PtrnFound, 1'b1);

    // 3: parity faults on ciphertext bytes 30 and 45
    encode(7'h01, 0);
    cin[30] ^= 8'h01;
    cin[45] ^= 8'h01;
    run_and_check(1'b0);
    check("t3_mem20", out_mem[20], 8'h80);
    check("t3_mem35", out_mem[35], 8'h80);
    check("t3_err", ErrCount, 7'd2);

    // 4: three leading spaces, preamble 15
    set_msg(15, {"   ", msg});
    encode(7'h2B, 3);
    run_and_check(1'b0);
    check("t4_mem0", out_mem[0], 8'h2D);
    check("t4_mem63", out_mem[63], 8'h00);

    // 5: reset pulse during decrypt, then a clean run
    set_msg(10, msg);
    encode(7'h01, 0);
    launch(1'b0);
    repeat (40) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk); #1 Reset = 1'b1;
    @(negedge Clk);
    check("t5_ack", Ack, 1'b0);
    check("t5_wren", MemWrEn, 1'b0);
    check("t5_err", ErrCount, 7'd0);
    check("t5_found", PtrnFound, 1'b0);
    repeat (5) @(negedge Clk);
    check("t5_idle_wren", MemWrEn, 1'b0);
    run_and_check(1'b0);

    // 6: corrupted preamble, no pattern fits
    encode(7'h01, 0);
    cin[5] ^= 8'h03;
    run_and_check(1'b0);
    check("t6_found", PtrnFound, 1'b0);
    check("t6_idx", PtrnIdx, 4'd0);
    check("t6_writes", wr_cnt, 64);

    // Random runs
    for (int r = 0; r < 6; r++) begin
      pidx = $urandom_range(0, 8);
      seed = 7'($urandom_range(1, 127));
      pre  = $urandom_range(10, 20);
      for (int i = 0; i < 64; i++)
        plain[i] = (i < pre || $urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom_range(0, 94));
      encode(seed, pidx);
      for (int i = pre; i < 64; i++) if ($urandom_range(0, 15) == 0) cin[i] ^= 8'h10;
      run_and_check(r[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
